alu_exec_stage: RTL and testbench

//  Registered execute stage directly downstream of the ALU-control decoder: takes alu_control plus
//  two operands, computes AND/OR/ADD/SUB, and presents result + zero flag (for beq) one cycle later.

---
 rtl/alu_exec_stage.sv | 138 +++++++++++++
 tb/tb_alu_exec_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - registered AND/OR/ADD/SUB execute stage with 2-entry skid buffer
// Valid/ready on both sides; OUT register drives the outputs, SKID absorbs one beat of backpressure.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal,
  output logic            err_sticky
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic [XLEN-1:0] calc_res;
  logic            calc_ill;
  logic            calc_zero;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_res_q, out_res_d;
  logic            out_zero_q, out_zero_d;
  logic            out_ill_q, out_ill_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_res_q, skid_res_d;
  logic            skid_zero_q, skid_zero_d;
  logic            skid_ill_q, skid_ill_d;
  logic            err_q, err_d;

  logic accept;
  logic emit;

  always_comb begin
    calc_res = '0;
    calc_ill = 1'b0;
    case (alu_control)
      OP_AND:  calc_res = op_a & op_b;
      OP_OR:   calc_res = op_a | op_b;
      OP_ADD:  calc_res = op_a + op_b;
      OP_SUB:  calc_res = op_a - op_b;
      default: calc_ill = 1'b1;
    endcase
    calc_zero = !calc_ill && (calc_res == '0);
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_res_d    = out_res_q;
    out_zero_d   = out_zero_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_res_d   = skid_res_q;
    skid_zero_d  = skid_zero_q;
    skid_ill_d   = skid_ill_q;
    err_d        = err_q;

    if (flush) begin
      // Flushed beats never reach the sticky error, even if accepted this cycle.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (accept) begin
        out_valid_d = 1'b1;
        out_res_d   = calc_res;
        out_zero_d  = calc_zero;
        out_ill_d   = calc_ill;
      end
    end else if (!skid_valid_q) begin
      if (accept && emit) begin
        out_res_d  = calc_res;
        out_zero_d = calc_zero;
        out_ill_d  = calc_ill;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_res_d   = calc_res;
        skid_zero_d  = calc_zero;
        skid_ill_d   = calc_ill;
      end else if (emit) begin
        out_valid_d = 1'b0;
      end
    end else if (emit) begin
      out_res_d    = skid_res_q;
      out_zero_d   = skid_zero_q;
      out_ill_d    = skid_ill_q;
      skid_valid_d = 1'b0;
    end

    if (!flush && accept && calc_ill) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_res_q    <= '0;
      out_zero_q   <= 1'b0;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_res_q   <= '0;
      skid_zero_q  <= 1'b0;
      skid_ill_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_res_q    <= out_res_d;
      out_zero_q   <= out_zero_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_res_q   <= skid_res_d;
      skid_zero_q  <= skid_zero_d;
      skid_ill_q   <= skid_ill_d;
      err_q        <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = out_res_q;
  assign zero       = out_zero_q;
  assign illegal    = out_ill_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - self-checking bench for alu_exec_stage against a queue-based model
// The model treats the stage as a FIFO of at most two computed beats.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic        zero, illegal, err_sticky;
  logic [3:0]  alu_control;
  logic [31:0] op_a, op_b, result;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        ill;
  } beat_t;

  beat_t q[$];
  logic  m_err;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal), .err_sticky(err_sticky)
  );

  function automatic beat_t ref_beat(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    beat_t r;
    longint unsigned m, ua, ub;
    m  = 64'h1_0000_0000;
    ua = longint'(a);
    ub = longint'(b);
    r.ill = 1'b0;
    r.res = '0;
    case (c)
      4'd0:    r.res = a & b;
      4'd1:    r.res = a | b;
      4'd2:    r.res = 32'((ua + ub) % m);
      4'd6:    r.res = 32'((ua + m - ub) % m);
      default: r.ill = 1'b1;
    endcase
    r.z = !r.ill && (r.res == 32'd0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    if (q.size() != 0) begin
      check("result", result, q[0].res);
      check("zero", 32'(zero), 32'(q[0].z));
      check("illegal", 32'(illegal), 32'(q[0].ill));
    end
  endtask

  // Drives one cycle of inputs, advances the model at the edge, then compares.
  task automatic cyc(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, input logic fl);
    logic  acc, emt;
    beat_t nb;
    in_valid    = v;
    alu_control = c;
    op_a        = a;
    op_b        = b;
    out_ready   = ordy;
    flush       = fl;
    acc = v && (q.size() < 2);
    emt = (q.size() != 0) && ordy;
    nb  = ref_beat(c, a, b);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (emt) void'(q.pop_front());
      if (acc) begin
        q.push_back(nb);
        if (nb.ill) m_err = 1'b1;
      end
    end
    #1;
    model_check();
  endtask

  initial begin
    logic        v;
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [3:0]  codes [6];

    codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd2;
    codes[3] = 4'd6; codes[4] = 4'hF; codes[5] = 4'd9;

    m_err = 1'b0;
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = '0; op_a = '0; op_b = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic ADD, then zero results from SUB and from wraparound ADD.
    cyc(1, 4'd2, 32'd5, 32'd3, 1, 0);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_result", result, 32'd8);
    check("t1_zero", 32'(zero), 32'd0);
    cyc(1, 4'd6, 32'h1234_5678, 32'h1234_5678, 1, 0);
    check("t2_sub_res", result, 32'd0);
    check("t2_sub_zero", 32'(zero), 32'd1);
    cyc(1, 4'd2, 32'hFFFF_FFFF, 32'd1, 1, 0);
    check("t2_wrap_res", result, 32'd0);
    check("t2_wrap_zero", 32'(zero), 32'd1);
    cyc(0, 4'd0, 32'd0, 32'd0, 1, 0);

    // Backpressure fills OUT then SKID; release drains in order.
    cyc(1, 4'd0, 32'h0000_F0F0, 32'h0000_FF00, 0, 0);
    cyc(1, 4'd1, 32'h0000_000F, 32'h0000_00F0, 0, 0);
    check("t3_full_ready", 32'(in_ready), 32'd0);
    check("t3_first", result, 32'h0000_F000);
    cyc(0, 4'd0, 32'd0, 32'd0, 1, 0);
    check("t3_second", result, 32'h0000_00FF);
    check("t3_second_valid", 32'(out_valid), 32'd1);
    check("t3_ready_back", 32'(in_ready), 32'd1);
    cyc(0, 4'd0, 32'd0, 32'd0, 1, 0);
    check("t3_drained", 32'(out_valid), 32'd0);

    // Illegal code sets the sticky error, which survives legal traffic.
    cyc(1, 4'hF, 32'd7, 32'd7, 1, 0);
    check("t4_illegal", 32'(illegal), 32'd1);
    check("t4_result", result, 32'd0);
    check("t4_zero", 32'(zero), 32'd0);
    check("t4_err", 32'(err_sticky), 32'd1);
    cyc(1, 4'd2, 32'd1, 32'd1, 1, 0);
    cyc(1, 4'd0, 32'd3, 32'd1, 1, 0);
    check("t4_err_stays", 32'(err_sticky), 32'd1);

    // Flush while FULL: no stale beat appears afterwards.
    cyc(0, 4'd0, 32'd0, 32'd0, 1, 0);
    cyc(1, 4'd2, 32'd10, 32'd20, 0, 0);
    cyc(1, 4'd2, 32'd30, 32'd40, 0, 0);
    cyc(0, 4'd0, 32'd0, 32'd0, 0, 1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_ready", 32'(in_ready), 32'd1);
    cyc(0, 4'd0, 32'd0, 32'd0, 1, 0);
    cyc(0, 4'd0, 32'd0, 32'd0, 1, 0);
    check("t5_no_stale", 32'(out_valid), 32'd0);

    // Random traffic with an asynchronous reset in the middle.
    v = 1'b0; c = '0; a = '0; b = '0;
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_zero", 32'(zero), 32'd0);
        check("arst_illegal", 32'(illegal), 32'd0);
        check("arst_err", 32'(err_sticky), 32'd0);
        q.delete();
        m_err = 1'b0;
        v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end
      if (!(v && q.size() >= 2)) begin
        v = ($urandom_range(0, 9) < 7);
        c = codes[$urandom_range(0, 5)];
        a = $urandom;
        b = ($urandom_range(0, 7) == 0) ? a : $urandom;
        if ($urandom_range(0, 15) == 0) b = 32'd0 - a;
      end
      cyc(v, c, a, b, ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
